// File: rtl/mem_arbiter_if.sv
// Shared bus bundle for the two-client burst arbiter: both cache ports plus the memory port.
// slave is the arbiter's view; master is the surrounding system (caches + memory).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]     c1_addr, c2_addr;
  logic [BURSTLEN_WIDTH-1:0] c1_burst_len, c2_burst_len;
  logic [DATA_WIDTH-1:0]     c1_data_in, c2_data_in;
  logic                      c1_wr, c2_wr, c1_rd, c2_rd;
  logic [DATA_WIDTH-1:0]     c1_data_out, c2_data_out;
  logic                      c1_waitrequest, c2_waitrequest;
  logic                      c1_rd_valid, c2_rd_valid;

  logic [ADDR_WIDTH-1:0]     mm_addr;
  logic [BURSTLEN_WIDTH-1:0] mm_burst_len;
  logic [DATA_WIDTH-1:0]     mm_data_out;
  logic                      mm_wr, mm_rd;
  logic [DATA_WIDTH-1:0]     mm_data_in;
  logic                      mm_waitrequest, mm_rd_valid;

  modport slave (
    input  c1_addr, c2_addr, c1_burst_len, c2_burst_len, c1_data_in, c2_data_in,
           c1_wr, c2_wr, c1_rd, c2_rd, mm_data_in, mm_waitrequest, mm_rd_valid,
    output c1_data_out, c2_data_out, c1_waitrequest, c2_waitrequest,
           c1_rd_valid, c2_rd_valid, mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd
  );

  modport master (
    output c1_addr, c2_addr, c1_burst_len, c2_burst_len, c1_data_in, c2_data_in,
           c1_wr, c2_wr, c1_rd, c2_rd, mm_data_in, mm_waitrequest, mm_rd_valid,
    input  c1_data_out, c2_data_out, c1_waitrequest, c2_waitrequest,
           c1_rd_valid, c2_rd_valid, mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin burst arbiter: grants the memory port to one cache for a whole
// read or write burst, with a mandatory IDLE cycle between bursts.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

  localparam logic [BURSTLEN_WIDTH:0] ONE = 1;

  state_t                  state;
  logic                    last2;    // client 2 was the most recent owner
  logic [BURSTLEN_WIDTH:0] rem;
  logic                    rd_pend;  // read command accepted, beats outstanding
  logic                    wr_act;   // write burst has accepted its first beat

  logic                    owned, own2, rd_acc, wr_acc;
  logic [1:0]              req;
  logic [BURSTLEN_WIDTH:0] burst_ld, wr_cnt;

  assign owned    = (state != IDLE);
  assign own2     = (state == OWN2);
  assign req      = {bus.c2_rd | bus.c2_wr, bus.c1_rd | bus.c1_wr};
  assign rd_acc   = bus.mm_rd & ~bus.mm_waitrequest;
  assign wr_acc   = bus.mm_wr & ~bus.mm_waitrequest;
  assign burst_ld = {1'b0, bus.mm_burst_len} + ONE;
  // First write beat both loads the count and consumes itself.
  assign wr_cnt   = wr_act ? rem : burst_ld;

  assign bus.c1_data_out = bus.mm_data_in;
  assign bus.c2_data_out = bus.mm_data_in;

  always_comb begin
    bus.mm_addr        = '0;
    bus.mm_burst_len   = '0;
    bus.mm_data_out    = '0;
    bus.mm_rd          = 1'b0;
    bus.mm_wr          = 1'b0;
    bus.c1_waitrequest = 1'b1;
    bus.c2_waitrequest = 1'b1;
    bus.c1_rd_valid    = 1'b0;
    bus.c2_rd_valid    = 1'b0;
    if (owned) begin
      bus.mm_addr      = own2 ? bus.c2_addr      : bus.c1_addr;
      bus.mm_burst_len = own2 ? bus.c2_burst_len : bus.c1_burst_len;
      bus.mm_data_out  = own2 ? bus.c2_data_in   : bus.c1_data_in;
      bus.mm_rd        = (own2 ? bus.c2_rd : bus.c1_rd) & ~rd_pend;
      bus.mm_wr        = own2 ? bus.c2_wr : bus.c1_wr;
      if (own2) begin
        bus.c2_waitrequest = rd_pend | bus.mm_waitrequest;
        bus.c2_rd_valid    = rd_pend & bus.mm_rd_valid;
      end else begin
        bus.c1_waitrequest = rd_pend | bus.mm_waitrequest;
        bus.c1_rd_valid    = rd_pend & bus.mm_rd_valid;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last2   <= 1'b1;
      rem     <= '0;
      rd_pend <= 1'b0;
      wr_act  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_pend <= 1'b0;
          wr_act  <= 1'b0;
          // On a tie the client that did not own last wins.
          if (req[0] && (!req[1] || last2)) state <= OWN1;
          else if (req[1])                  state <= OWN2;
        end
        default: begin
          if (rd_acc) begin
            rd_pend <= 1'b1;
            rem     <= burst_ld;
          end else if (rd_pend && bus.mm_rd_valid) begin
            rem <= rem - ONE;
            if (rem == ONE) begin
              state   <= IDLE;
              last2   <= own2;
              rd_pend <= 1'b0;
            end
          end else if (wr_acc) begin
            rem    <= wr_cnt - ONE;
            wr_act <= 1'b1;
            if (wr_cnt == ONE) begin
              state  <= IDLE;
              last2  <= own2;
              wr_act <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, ties, stalled write, stray rd_valid, reset mid-burst.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mem_arbiter_if bus ();
  mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic wreq(input int w);
    return (w == 1) ? bus.c1_waitrequest : bus.c2_waitrequest;
  endfunction
  function automatic logic rdv(input int w);
    return (w == 1) ? bus.c1_rd_valid : bus.c2_rd_valid;
  endfunction
  function automatic logic [31:0] dout(input int w);
    return (w == 1) ? bus.c1_data_out : bus.c2_data_out;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, ".c1_wreq"}, bus.c1_waitrequest, 1);
    chk({tag, ".c2_wreq"}, bus.c2_waitrequest, 1);
    chk({tag, ".mm_rd"}, bus.mm_rd, 0);
    chk({tag, ".mm_wr"}, bus.mm_wr, 0);
    chk({tag, ".mm_addr"}, bus.mm_addr, 0);
    chk({tag, ".mm_bl"}, bus.mm_burst_len, 0);
    chk({tag, ".mm_dout"}, bus.mm_data_out, 0);
    chk({tag, ".c1_rdv"}, bus.c1_rd_valid, 0);
    chk({tag, ".c2_rdv"}, bus.c2_rd_valid, 0);
  endtask

  // Entered one cycle after grant; serves the whole read and ends in the hand-over IDLE cycle.
  task automatic do_read(input int who, input logic [31:0] addr, input int beats,
                         input logic [31:0] base);
    int oth;
    oth = (who == 1) ? 2 : 1;
    settle;
    chk("rd.mm_rd", bus.mm_rd, 1);
    chk("rd.mm_addr", bus.mm_addr, addr);
    chk("rd.mm_bl", bus.mm_burst_len, beats - 1);
    chk("rd.own_wreq", wreq(who), 0);
    chk("rd.oth_wreq", wreq(oth), 1);
    tick;
    if (who == 1) bus.c1_rd = 1'b0; else bus.c2_rd = 1'b0;
    settle;
    chk("rd.mm_rd_hold", bus.mm_rd, 0);
    chk("rd.own_wreq_hold", wreq(who), 1);
    for (int i = 0; i < beats; i++) begin
      bus.mm_rd_valid = 1'b1;
      bus.mm_data_in  = base + i;
      settle;
      chk("rd.own_rdv", rdv(who), 1);
      chk("rd.own_data", dout(who), base + i);
      chk("rd.oth_rdv", rdv(oth), 0);
      chk("rd.oth_wreq", wreq(oth), 1);
      chk("rd.mm_rd_beat", bus.mm_rd, 0);
      tick;
    end
    bus.mm_rd_valid = 1'b0;
    settle;
    idle_chk("rd.handover");
  endtask

  initial begin
    int beats;
    bus.c1_addr = '0; bus.c2_addr = '0;
    bus.c1_burst_len = '0; bus.c2_burst_len = '0;
    bus.c1_data_in = '0; bus.c2_data_in = '0;
    bus.c1_wr = 1'b0; bus.c2_wr = 1'b0; bus.c1_rd = 1'b0; bus.c2_rd = 1'b0;
    bus.mm_data_in = '0; bus.mm_waitrequest = 1'b0; bus.mm_rd_valid = 1'b0;

    #2;
    idle_chk("reset");
    tick;
    reset = 1'b0;
    tick;

    // Single 8-beat read from client 1
    bus.c1_rd = 1'b1; bus.c1_addr = 32'h100; bus.c1_burst_len = 3'd7;
    settle;
    chk("lat.c1_wreq", bus.c1_waitrequest, 1);
    chk("lat.mm_rd", bus.mm_rd, 0);
    tick;
    do_read(1, 32'h100, 8, 32'h0);

    // Stray rd_valid while idle
    tick;
    bus.mm_rd_valid = 1'b1; bus.mm_data_in = 32'h55;
    settle;
    chk("stray.c1_rdv", bus.c1_rd_valid, 0);
    chk("stray.c2_rdv", bus.c2_rd_valid, 0);
    chk("stray.bcast", bus.c2_data_out, 32'h55);
    bus.mm_rd_valid = 1'b0;

    // Tie after reset: c1 first, then c2, then c1 again
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.c1_rd = 1'b1; bus.c1_addr = 32'h200; bus.c1_burst_len = 3'd1;
    bus.c2_rd = 1'b1; bus.c2_addr = 32'h300; bus.c2_burst_len = 3'd0;
    tick;
    do_read(1, 32'h200, 2, 32'h20);
    tick;
    do_read(2, 32'h300, 1, 32'h30);
    tick;
    bus.c1_rd = 1'b1; bus.c1_addr = 32'h210; bus.c1_burst_len = 3'd0;
    bus.c2_rd = 1'b1; bus.c2_addr = 32'h310; bus.c2_burst_len = 3'd2;
    tick;
    do_read(1, 32'h210, 1, 32'h40);
    tick;
    do_read(2, 32'h310, 3, 32'h50);

    // Client 2 write of 4 beats with a 2-cycle memory stall mid-burst
    tick;
    bus.c2_wr = 1'b1; bus.c2_addr = 32'h400; bus.c2_burst_len = 3'd3; bus.c2_data_in = 32'hA;
    tick;
    beats = 0;
    for (int cyc = 0; cyc < 12 && beats < 4; cyc++) begin
      bus.mm_waitrequest = (cyc == 2 || cyc == 3);
      settle;
      chk("wr.c2_wreq", bus.c2_waitrequest, bus.mm_waitrequest);
      chk("wr.c1_wreq", bus.c1_waitrequest, 1);
      chk("wr.mm_wr", bus.mm_wr, 1);
      chk("wr.mm_addr", bus.mm_addr, 32'h400);
      chk("wr.mm_bl", bus.mm_burst_len, 3);
      chk("wr.data", bus.mm_data_out, 32'hA + beats);
      if (!bus.mm_waitrequest) beats++;
      tick;
      bus.c2_data_in = 32'hA + beats;
      if (beats == 4) bus.c2_wr = 1'b0;
    end
    bus.mm_waitrequest = 1'b0;
    chk("wr.beats", beats, 4);
    bus.c2_wr = 1'b0;
    settle;
    idle_chk("wr.done");

    // Reset after beat 3 of an 8-beat read, with a beat still in flight
    tick;
    bus.c1_rd = 1'b1; bus.c1_addr = 32'h500; bus.c1_burst_len = 3'd7;
    tick;
    settle;
    chk("rst.mm_rd", bus.mm_rd, 1);
    tick;
    bus.c1_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mm_rd_valid = 1'b1; bus.mm_data_in = 32'h60 + i;
      settle;
      chk("rst.pre_rdv", bus.c1_rd_valid, 1);
      tick;
    end
    bus.mm_rd_valid = 1'b1; bus.mm_data_in = 32'h63;
    reset = 1'b1;
    settle;
    idle_chk("rst.mid");
    tick;
    reset = 1'b0;
    bus.mm_rd_valid = 1'b0;
    // Tie after reset must again go to c1, and both bursts complete normally
    bus.c1_rd = 1'b1; bus.c1_addr = 32'h700; bus.c1_burst_len = 3'd0;
    bus.c2_rd = 1'b1; bus.c2_addr = 32'h600; bus.c2_burst_len = 3'd1;
    tick;
    do_read(1, 32'h700, 1, 32'h70);
    tick;
    do_read(2, 32'h600, 2, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
